// File: rtl/mux_uart_rx.sv
// MUX 0 serial receiver for CPU6: 8N1 deserialiser with a one-byte holding
// register, plus status/data registers on the CPU6 bus at BASE_ADDR/BASE_ADDR+1.
module mux_uart_rx #(
  parameter logic [18:0] BASE_ADDR    = 19'h3f200,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [18:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        rx,
  output logic        irq
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [18:0]       DATA_ADDR = BASE_ADDR + 19'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;

  rxState_t         r_state;
  rxState_t         w_stateNext;
  logic             r_rxMeta;
  logic             r_rxSync;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitCnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_holding;
  logic             r_rxReady;
  logic             r_fe;
  logic             r_ovr;
  logic             r_ie;
  logic             r_irq;
  logic             r_selQ;

  logic             w_tick;
  logic             w_cntClr;
  logic             w_shiftEn;
  logic             w_stopOk;
  logic             w_stopErr;
  logic             w_selD;
  logic             w_pop;
  logic             w_statusWr;

  assign w_tick     = (r_state == START) ? (r_cnt == CNT_HALF) : (r_cnt == CNT_LAST);
  assign w_selD     = (address == DATA_ADDR) & ~write_en;
  assign w_pop      = r_selQ & ~w_selD;
  assign w_statusWr = write_en & (address == BASE_ADDR);
  assign irq        = r_irq;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:  if (!r_rxSync) w_stateNext = START;
      START: if (w_tick) w_stateNext = r_rxSync ? IDLE : DATA;
      DATA:  if (w_tick && r_bitCnt == 3'd7) w_stateNext = STOP;
      STOP:  if (w_tick) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_cntClr  = 1'b0;
    w_shiftEn = 1'b0;
    w_stopOk  = 1'b0;
    w_stopErr = 1'b0;
    case (r_state)
      IDLE:  w_cntClr = 1'b1;
      START: w_cntClr = w_tick;
      DATA: begin
        w_cntClr  = w_tick;
        w_shiftEn = w_tick;
      end
      STOP: begin
        w_cntClr  = w_tick;
        w_stopOk  = w_tick & r_rxSync;
        w_stopErr = w_tick & ~r_rxSync;
      end
      default: w_cntClr = 1'b1;
    endcase
  end

  // A pop in the same cycle as a load frees the holding register, so the load is not an overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rxMeta  <= 1'b1;
      r_rxSync  <= 1'b1;
      r_cnt     <= '0;
      r_bitCnt  <= 3'd0;
      r_shift   <= 8'h00;
      r_holding <= 8'h00;
      r_rxReady <= 1'b0;
      r_fe      <= 1'b0;
      r_ovr     <= 1'b0;
      r_ie      <= 1'b0;
      r_irq     <= 1'b0;
      r_selQ    <= 1'b0;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
      r_selQ   <= w_selD;
      r_irq    <= r_ie & r_rxReady;
      r_cnt    <= w_cntClr ? '0 : r_cnt + CNT_W'(1);
      if (w_shiftEn) begin
        r_shift  <= {r_rxSync, r_shift[7:1]};
        r_bitCnt <= r_bitCnt + 3'd1;
      end else if (r_state == START) begin
        r_bitCnt <= 3'd0;
      end
      if (w_stopOk && (!r_rxReady || w_pop)) begin
        r_holding <= r_shift;
        r_rxReady <= 1'b1;
      end else if (w_pop) begin
        r_rxReady <= 1'b0;
      end
      if (w_stopOk && r_rxReady && !w_pop) r_ovr <= 1'b1;
      else if (w_statusWr && data_in[3])   r_ovr <= 1'b0;
      if (w_stopErr)                       r_fe <= 1'b1;
      else if (w_statusWr && data_in[2])   r_fe <= 1'b0;
      if (w_statusWr) r_ie <= data_in[7];
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (address == BASE_ADDR)      data_out = {r_ie, 3'b000, r_ovr, r_fe, 1'b1, r_rxReady};
    else if (address == DATA_ADDR) data_out = r_holding;
  end

endmodule

// File: tb/tb_mux_uart_rx.sv
// Directed bench for mux_uart_rx: frames are driven on rx at 16 clocks/bit and
// the bus registers and irq are checked against hand-computed values.
module tb_mux_uart_rx;

  localparam logic [18:0] BASE = 19'h3f200;
  localparam logic [18:0] DATA = 19'h3f201;

  logic        clock = 1'b0;
  logic        reset;
  logic [18:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        rx;
  logic        irq;
  int          checks   = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  mux_uart_rx #(.BASE_ADDR(19'h3f200), .CLKS_PER_BIT(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(data_out),
    .rx      (rx),
    .irq     (irq)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [18:0] addr, input logic we, input logic [7:0] din);
    address  = addr;
    write_en = we;
    data_in  = din;
  endtask

  // One clock edge passes with the address applied before data_out is sampled.
  task automatic checkRead(input string tag, input logic [18:0] addr, input logic [7:0] expected);
    applyStimulus(addr, 1'b0, 8'h00);
    @(negedge clock);
    #1;
    checkOutput(tag, data_out, expected);
  endtask

  task automatic busWrite(input logic [18:0] addr, input logic [7:0] din);
    applyStimulus(addr, 1'b1, din);
    @(negedge clock);
    #1;
    applyStimulus(addr, 1'b0, 8'h00);
  endtask

  task automatic sendFrame(input logic [7:0] value, input logic stopBit);
    @(negedge clock);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = value[i];
      repeat (16) @(negedge clock);
    end
    rx = stopBit;
    repeat (16) @(negedge clock);
    rx = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    applyStimulus(19'h0, 1'b0, 8'h00);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;

    // Reset state
    checkRead("reset_status", BASE, 8'h02);
    checkRead("reset_data", DATA, 8'h00);
    checkOutput("reset_irq", {7'b0, irq}, 8'h00);

    // Single byte with latency boundary: still empty after 154 clocks, ready after 155
    applyStimulus(BASE, 1'b0, 8'h00);
    fork
      sendFrame(8'h41, 1'b1);
      begin
        @(negedge clock);
        repeat (154) @(negedge clock);
        #1;
        checkOutput("latency_before", data_out, 8'h02);
        @(negedge clock);
        #1;
        checkOutput("latency_ready", data_out, 8'h03);
      end
    join
    checkRead("rx41_data", DATA, 8'h41);
    checkRead("rx41_hold_addr", DATA, 8'h41);
    checkRead("rx41_after_pop", BASE, 8'h02);

    // Overrun: second byte dropped, first kept
    applyStimulus(19'h0, 1'b0, 8'h00);
    sendFrame(8'h55, 1'b1);
    sendFrame(8'hAA, 1'b1);
    checkRead("ovr_status", BASE, 8'h0B);
    busWrite(BASE, 8'h08);
    checkRead("ovr_cleared", BASE, 8'h03);
    checkRead("ovr_kept_byte", DATA, 8'h55);
    checkRead("ovr_after_pop", BASE, 8'h02);

    // Framing error, then a short false start
    applyStimulus(19'h0, 1'b0, 8'h00);
    sendFrame(8'h33, 1'b0);
    repeat (20) @(negedge clock);
    checkRead("fe_status", BASE, 8'h06);
    @(negedge clock);
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (200) @(negedge clock);
    checkRead("false_start", BASE, 8'h06);
    busWrite(BASE, 8'h04);
    checkRead("fe_cleared", BASE, 8'h02);

    // Interrupt enable and irq timing
    busWrite(BASE, 8'h80);
    checkRead("ie_status", BASE, 8'h82);
    fork
      sendFrame(8'h0D, 1'b1);
      begin
        @(negedge clock);
        repeat (155) @(negedge clock);
        #1;
        checkOutput("irq_ready_status", data_out, 8'h83);
        checkOutput("irq_lag", {7'b0, irq}, 8'h00);
        @(negedge clock);
        #1;
        checkOutput("irq_set", {7'b0, irq}, 8'h01);
      end
    join
    checkRead("irq_data", DATA, 8'h0D);
    checkRead("irq_pop_status", BASE, 8'h82);
    checkOutput("irq_pop_lag", {7'b0, irq}, 8'h01);
    @(negedge clock);
    #1;
    checkOutput("irq_cleared", {7'b0, irq}, 8'h00);

    // Reset in the middle of the data bits abandons the frame
    applyStimulus(19'h0, 1'b0, 8'h00);
    @(negedge clock);
    rx = 1'b0;
    repeat (16) @(negedge clock);
    rx = 1'b1;
    repeat (24) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    checkRead("midreset_status", BASE, 8'h02);
    checkOutput("midreset_irq", {7'b0, irq}, 8'h00);
    checkRead("midreset_data", DATA, 8'h00);
    applyStimulus(19'h0, 1'b0, 8'h00);
    sendFrame(8'h5A, 1'b1);
    checkRead("rx5A_status", BASE, 8'h03);
    checkRead("rx5A_data", DATA, 8'h5A);

    // Pop lands on the same edge as the next load: new byte kept, no overrun
    fork
      sendFrame(8'hC3, 1'b1);
      begin
        @(negedge clock);
        repeat (154) @(negedge clock);
        applyStimulus(BASE, 1'b0, 8'h00);
        @(negedge clock);
        #1;
        checkOutput("poploadStatus", data_out, 8'h03);
      end
    join
    checkRead("popload_data", DATA, 8'hC3);
    checkRead("popload_after_pop", BASE, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
